alu_acc: RTL and testbench

- Accumulator/ALU stage directly downstream of the 4:1 operand mux in the expression-solver datapath.
- Consumes the mux output MX as its operand and applies LOAD/ADD/SUB/MUL to an internal accumulator.
- Start/busy/done handshake lets the control FSM sequence multi-step expressions.
- MUL is a multi-cycle shift-add; all other ops complete in one cycle.

---
 rtl/alu_acc.sv | 147 ++++++++++++++
 tb/tb_alu_acc.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_acc.sv
// Accumulator/ALU stage fed by the operand mux: LOAD/ADD/SUB in one cycle, MUL as a WIDTH-cycle shift-add.
// Latency: 1 edge for LOAD/ADD/SUB, WIDTH edges after accept for MUL; start is ignored while busy (no queueing).
module alu_acc #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand,
   input  logic             clear,
   output logic [WIDTH-1:0] acc,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_MUL  = 2'b11;
   localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] hi_nxt, lo_nxt;
   logic             last_iter;

   assign add_full  = {1'b0, acc_q} + {1'b0, operand};
   assign last_iter = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));

   // {hi,lo} holds the partial product in its upper half and the unconsumed multiplier bits in its lower half
   assign step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
   assign hi_nxt   = step_sum[WIDTH:1];
   assign lo_nxt   = {step_sum[0], lo_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: if (start && op == OP_MUL) state_d = S_MUL;
            S_MUL:  if (last_iter)            state_d = S_IDLE;
            default:                          state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy     = (state_q == S_MUL);
      acc      = acc_q;
      done     = done_q;
      overflow = ovf_q;
   end

   always_comb begin
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      if (clear) begin
         acc_d   = '0;
         ovf_d   = 1'b0;
         hi_d    = '0;
         lo_d    = '0;
         mcand_d = '0;
         cnt_d   = '0;
      end else if (state_q == S_IDLE) begin
         if (start) begin
            unique case (op)
               OP_LOAD: begin
                  acc_d  = operand;
                  ovf_d  = 1'b0;
                  done_d = 1'b1;
               end
               OP_ADD: begin
                  acc_d  = add_full[WIDTH-1:0];
                  ovf_d  = ovf_q | add_full[WIDTH];
                  done_d = 1'b1;
               end
               OP_SUB: begin
                  acc_d  = acc_q - operand;
                  ovf_d  = ovf_q | (operand > acc_q);
                  done_d = 1'b1;
               end
               OP_MUL: begin
                  hi_d    = '0;
                  lo_d    = acc_q;
                  mcand_d = operand;
                  cnt_d   = '0;
               end
               default: ;
            endcase
         end
      end else begin
         hi_d  = hi_nxt;
         lo_d  = lo_nxt;
         cnt_d = cnt_q + CW'(1);
         if (last_iter) begin
            acc_d  = lo_nxt;
            ovf_d  = ovf_q | (|hi_nxt);
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
      end else begin
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_acc.sv
// Directed-vector bench for alu_acc with hand-computed expectations.
module tb_alu_acc;

   localparam logic [1:0] LOAD = 2'b00;
   localparam logic [1:0] ADD  = 2'b01;
   localparam logic [1:0] SUB  = 2'b10;
   localparam logic [1:0] MUL  = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [15:0] operand;
   logic        clear;
   logic [15:0] acc;
   logic        busy;
   logic        done;
   logic        overflow;

   int n_chk  = 0;
   int n_pass = 0;
   int done_cnt;

   alu_acc #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .operand(operand),
      .clear(clear), .acc(acc), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] o, input logic [15:0] v);
      start   = 1'b1;
      op      = o;
      operand = v;
      tick();
      start   = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic [15:0] a, input logic b,
                            input logic d, input logic ov);
      check({tag, ".acc"}, 32'(acc), 32'(a));
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".done"}, 32'(done), 32'(d));
      check({tag, ".ovf"}, 32'(overflow), 32'(ov));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = LOAD; operand = '0; clear = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      check_all("rst_init", 16'h0000, 0, 0, 0);

      // async reset mid-cycle, while done and overflow are high
      issue(LOAD, 16'h00AB);
      check("ld_ab", 32'(acc), 32'h00AB);
      issue(ADD, 16'hFFFF);
      check_all("pre_rst", 16'h00AA, 0, 1, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_all("rst_async", 16'h0000, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check_all("rst_idle3", 16'h0000, 0, 0, 0);

      // back-to-back LOAD/ADD
      issue(LOAD, 16'h0005);
      check_all("load5", 16'h0005, 0, 1, 0);
      issue(ADD, 16'h0003);
      check_all("add3", 16'h0008, 0, 1, 0);
      tick();
      check_all("idle_hold", 16'h0008, 0, 0, 0);

      // wrap/borrow and sticky overflow
      issue(ADD, 16'hFFFF);
      check_all("add_ffff", 16'h0007, 0, 1, 1);
      issue(SUB, 16'h0008);
      check_all("sub8", 16'hFFFF, 0, 1, 1);
      issue(LOAD, 16'h0001);
      check_all("load1", 16'h0001, 0, 1, 0);
      issue(SUB, 16'h0001);
      check_all("sub_noborrow", 16'h0000, 0, 1, 0);

      // MUL 0x12*0x34 with ignored starts while busy
      issue(LOAD, 16'h0012);
      issue(MUL, 16'h0034);
      check_all("mul_acc_N", 16'h0012, 1, 0, 0);
      for (int k = 1; k <= 16; k++) begin
         start   = 1'b1;
         op      = LOAD;
         operand = 16'hBE00 + 16'(k);
         tick();
         start   = 1'b0;
         if (k < 16) begin
            check($sformatf("mul_busy_%0d", k), 32'({busy, done, acc}), 32'({1'b1, 1'b0, 16'h0012}));
         end else begin
            check_all("mul_res", 16'h03A8, 0, 1, 0);
         end
      end
      tick();
      check_all("mul_after", 16'h03A8, 0, 0, 0);

      // MUL overflow, then start accepted during the done cycle
      issue(LOAD, 16'h0100);
      issue(MUL, 16'h0100);
      repeat (15) tick();
      check_all("mulov_busy", 16'h0100, 1, 0, 0);
      tick();
      check_all("mulov_res", 16'h0000, 0, 1, 1);
      issue(LOAD, 16'h0002);
      check_all("acc_after_done", 16'h0002, 0, 1, 0);
      tick();
      check("done_single", 32'(done), 32'h0);

      // clear aborts MUL at cycle 5, simultaneous start dropped
      issue(LOAD, 16'h0003);
      issue(ADD, 16'hFFFF);
      check_all("pre_clr", 16'h0002, 0, 1, 1);
      issue(MUL, 16'h0005);
      repeat (4) tick();
      clear = 1'b1; start = 1'b1; op = LOAD; operand = 16'h0077;
      tick();
      clear = 1'b0; start = 1'b0;
      check_all("clr_abort", 16'h0000, 0, 0, 0);
      done_cnt = 0;
      repeat (20) begin
         tick();
         if (done) done_cnt++;
      end
      check("clr_no_done", 32'(done_cnt), 32'd0);
      check_all("clr_settled", 16'h0000, 0, 0, 0);

      // async reset aborts MUL at cycle 7
      issue(LOAD, 16'h0004);
      issue(ADD, 16'hFFFF);
      issue(MUL, 16'h0006);
      repeat (6) tick();
      check_all("pre_arst", 16'h0003, 1, 0, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_all("arst_abort", 16'h0000, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      done_cnt = 0;
      repeat (20) begin
         tick();
         if (done) done_cnt++;
      end
      check("arst_no_done", 32'(done_cnt), 32'd0);
      check_all("arst_settled", 16'h0000, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
